// File: rtl/dtcm_ctrl_pkg.sv
// Shared sizing for the DTCM responder slice.
// No ports. It provides the RAM geometry defaults and the response buffer depth.
package dtcm_ctrl_pkg;

    localparam int unsigned DTCM_RAM_AW = 10;
    localparam int unsigned DTCM_RAM_DW = 32;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned RBUF_DEPTH  = 2;

endpackage

// File: rtl/dtcm_ctrl_if.sv
// LSU-to-DTCM command/response bus.
// Command channel (valid/ready, read, addr, wdata, wmask).
// Response channel (valid/ready, rdata).
// dtcm_active is an activity hint that the responder drives back to the LSU side.
interface dtcm_ctrl_if
    import dtcm_ctrl_pkg::*;
#(
    parameter int unsigned AW = DTCM_RAM_AW,
    parameter int unsigned DW = XLEN,
    parameter int unsigned MW = DW / 8
) ();

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          dtcm_active;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, dtcm_active
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, dtcm_active
    );

endinterface

// File: rtl/dtcm_ram.sv
// Behavioural 1RW DTCM SRAM with per-byte write enables and a 1-cycle read.
// Ports:
//   clk       clock
//   i_en      access enable (one access per cycle)
//   i_we      1 = write, 0 = read
//   i_addr    word address
//   i_wdata   write data
//   i_wmask   byte enables for writes
//   o_dout    registered read data; holds until the next read
module dtcm_ram
    import dtcm_ctrl_pkg::*;
#(
    parameter int unsigned AW = DTCM_RAM_AW,
    parameter int unsigned DW = DTCM_RAM_DW,
    parameter int unsigned MW = DW / 8
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic [MW-1:0] i_wmask,
    output logic [DW-1:0] o_dout
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;

    // Contents are deliberately not reset, matching the hard macro.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < int'(MW); i++) begin
                    if (i_wmask[i]) begin
                        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/dtcm_ctrl.sv
// DTCM responder. It executes LSU loads and stores on the single-port RAM and returns
// one in-order response per command. A 2-entry response buffer absorbs
// response back-pressure, and stage-1 results bypass it when it is empty.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    slave side of dtcm_ctrl_if (command, response, dtcm_active)
module dtcm_ctrl
    import dtcm_ctrl_pkg::*;
#(
    parameter int unsigned AW = DTCM_RAM_AW,
    parameter int unsigned DW = XLEN,
    parameter int unsigned MW = DW / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dtcm_ctrl_if.slave     bus
);

    localparam logic [1:0] MAX_OUTST = 2'(RBUF_DEPTH);

    logic [1:0]    r_outst;
    logic          r_s1_valid;
    logic          r_s1_read;
    logic [DW-1:0] r_rbuf [RBUF_DEPTH];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    logic [DW-1:0] w_ram_dout;
    logic [DW-1:0] w_s1_data;
    logic          w_accept;
    logic          w_rsp_fire;
    logic          w_rbuf_empty;
    logic          w_push;
    logic          w_pop;

    // Credit-based ready: depends only on registered state and reset.
    assign bus.cmd_ready   = rst_n && (r_outst != MAX_OUTST);
    assign w_accept        = bus.cmd_valid && bus.cmd_ready;

    assign w_rbuf_empty    = (r_count == 2'd0);
    assign bus.rsp_valid   = !w_rbuf_empty || r_s1_valid;
    assign w_rsp_fire      = bus.rsp_valid && bus.rsp_ready;

    // Store responses carry zero data.
    assign w_s1_data       = r_s1_read ? w_ram_dout : '0;

    // The buffer head is older than stage 1, so it wins.
    assign bus.rsp_rdata   = !w_rbuf_empty ? r_rbuf[r_rd_ptr]
                           : (r_s1_valid   ? w_s1_data : '0);

    // Stage 1 goes straight out only when nothing is queued ahead of it.
    assign w_push          = r_s1_valid && !(w_rbuf_empty && bus.rsp_ready);
    assign w_pop           = !w_rbuf_empty && bus.rsp_ready;

    assign bus.dtcm_active = bus.cmd_valid || (r_outst != 2'd0);

    dtcm_ram #(
        .AW (AW),
        .DW (DW),
        .MW (MW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (!bus.cmd_read),
        .i_addr  (bus.cmd_addr),
        .i_wdata (bus.cmd_wdata),
        .i_wmask (bus.cmd_wmask),
        .o_dout  (w_ram_dout)
    );

    // Control state: credits, RAM stage, buffer pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outst    <= 2'd0;
            r_s1_valid <= 1'b0;
            r_s1_read  <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_outst    <= r_outst + 2'(w_accept) - 2'(w_rsp_fire);
            r_s1_valid <= w_accept;
            r_s1_read  <= bus.cmd_read;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_rbuf[r_wr_ptr] <= w_s1_data;
        end
    end

    a_credit_match: assert property (@(posedge clk) disable iff (!rst_n)
        r_outst == 2'(r_s1_valid) + r_count);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && r_count == MAX_OUTST));

endmodule

// File: tb/tb_dtcm_ctrl.sv
module tb_dtcm_ctrl;

    logic clk;
    logic rst_n;

    dtcm_ctrl_if #(.AW(10), .DW(32), .MW(4)) bus ();

    dtcm_ctrl #(.AW(10), .DW(32), .MW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] exp;
    } vec_t;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference model: word memory plus a queue of owed responses, in order.
    logic [31:0] mm [16];
    logic [31:0] q [$];
    logic [31:0] s_rdata;
    logic        s_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle, compare against the model mid-cycle, then advance it.
    task automatic cycle(input logic rn, input logic v, input logic rd,
                         input logic [9:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, input logic rr);
        logic        exp_ready;
        logic        acc;
        logic        fire;
        logic [31:0] w;
        rst_n         = rn;
        bus.cmd_valid = v;
        bus.cmd_read  = rd;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_wmask = wm;
        bus.rsp_ready = rr;
        #3;
        exp_ready = rn && (q.size() < 2);
        chk("cmd_ready",   32'(bus.cmd_ready),   32'(exp_ready));
        chk("rsp_valid",   32'(bus.rsp_valid),   32'(q.size() != 0));
        chk("dtcm_active", 32'(bus.dtcm_active), 32'(v || (q.size() != 0)));
        chk("outst",       32'(dut.r_outst),     32'(q.size()));
        if (q.size() != 0) chk("rsp_rdata", bus.rsp_rdata, q[0]);
        else if (!rn)      chk("rsp_rdata_rst", bus.rsp_rdata, 32'h0);
        s_rdata = bus.rsp_rdata;
        s_valid = bus.rsp_valid;
        fire = rr && (q.size() != 0);
        acc  = v && exp_ready;
        if (fire) void'(q.pop_front());
        if (acc) begin
            if (rd) begin
                q.push_back(mm[a[3:0]]);
            end else begin
                w = mm[a[3:0]];
                for (int i = 0; i < 4; i++) if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
                mm[a[3:0]] = w;
                q.push_back(32'h0);
            end
        end
        if (!rn) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        cycle(1'b1, 1'b0, 1'b1, 10'd0, 32'h0, 4'h0, rr);
    endtask

    vec_t tbl [10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b1; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wmask = '0;  bus.rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) mm[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // Checked reset cycles, with cmd_valid both low and high.
        cycle(1'b0, 1'b0, 1'b1, 10'd0, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 10'd0, 32'h0, 4'h0, 1'b1);

        // Preload the model-tracked window.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 10'(i), $urandom, 4'hF, 1'b1);
        idle(1'b1);

        // Table vectors, back-to-back; each response is checked one cycle after issue.
        tbl[0] = '{1'b0, 10'd5, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[1] = '{1'b1, 10'd5, 32'h0,        4'h0, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 10'd7, 32'hAABBCCDD, 4'hF, 32'h0};
        tbl[3] = '{1'b0, 10'd7, 32'h11223344, 4'h5, 32'h0};
        tbl[4] = '{1'b1, 10'd7, 32'h0,        4'hF, 32'hAA22CC44};
        tbl[5] = '{1'b0, 10'd7, 32'hFFFFFFFF, 4'h0, 32'h0};
        tbl[6] = '{1'b1, 10'd7, 32'h0,        4'h0, 32'hAA22CC44};
        tbl[7] = '{1'b0, 10'd7, 32'h00000099, 4'h8, 32'h0};
        tbl[8] = '{1'b1, 10'd7, 32'h0,        4'h0, 32'h0022CC44};
        tbl[9] = '{1'b1, 10'd5, 32'h0,        4'h0, 32'hDEADBEEF};
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].wm, 1'b1);
            if (i > 0) begin
                chk("tbl_valid", 32'(s_valid), 32'h1);
                chk("tbl_rdata", s_rdata, tbl[i-1].exp);
            end
        end
        idle(1'b1);
        chk("tbl_valid", 32'(s_valid), 32'h1);
        chk("tbl_rdata", s_rdata, tbl[9].exp);
        idle(1'b1);

        // Streaming: 64 back-to-back loads.
        for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 1'b1, 10'($urandom_range(0, 15)), 32'h0, 4'h0, 1'b1);
        idle(1'b1);

        // Back-pressure: addr 3 must wait for one consume.
        cycle(1'b1, 1'b1, 1'b1, 10'd1, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 10'd2, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 10'd3, 32'h0, 4'h0, 1'b0);
        chk("bp_ready_low", 32'(bus.cmd_ready), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 10'd3, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 10'd3, 32'h0, 4'h0, 1'b1);
        chk("bp_data1", s_rdata, mm[1]);
        cycle(1'b1, 1'b1, 1'b1, 10'd3, 32'h0, 4'h0, 1'b0);
        chk("bp_data2_held", s_rdata, mm[2]);
        idle(1'b1);
        idle(1'b1);
        chk("bp_data3", s_rdata, mm[3]);
        idle(1'b1);

        // Mid-operation reset with a store and a load pending.
        cycle(1'b1, 1'b1, 1'b0, 10'd9, 32'hCAFEF00D, 4'hF, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 10'd9, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 10'd9, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 10'd9, 32'h0, 4'h0, 1'b0);
        chk("rst_rsp_valid", 32'(s_valid), 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 10'd9, 32'h0, 4'h0, 1'b1);
        idle(1'b1);
        chk("rst_store_kept", s_rdata, 32'hCAFEF00D);
        idle(1'b1);

        // Random soak.
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
        end
        repeat (4) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
